// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: locks onto a sync marker and splits each frame
// of NUM_CH slots, WIDTH bits each (MSB first), into per-channel registers.
module tdm_demux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    data_in,
  input  logic                    valid_in,
  input  logic                    sync_in,
  output logic [NUM_CH*WIDTH-1:0] ch_data_out,
  output logic [NUM_CH-1:0]       ch_valid_out,
  output logic                    frame_done_out,
  output logic                    sync_err_out,
  output logic                    locked_out
);

  localparam int unsigned BW  = $clog2(WIDTH);
  localparam int unsigned SW  = $clog2(NUM_CH);
  localparam int unsigned SHW = WIDTH - 1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    RECEIVE = 2'd1,
    EXPECT  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [SW-1:0]           slot_cnt_q;
  logic [SHW-1:0]          shift_q;
  logic [NUM_CH*WIDTH-1:0] ch_data_q;
  logic [NUM_CH-1:0]       ch_valid_q;
  logic                    frame_done_q;
  logic                    sync_err_q;
  logic                    locked_q;

  logic [WIDTH-1:0]        word_c;
  logic                    last_bit_c;
  logic                    last_slot_c;
  logic                    resync_c;

  // Word being completed this cycle and slot-position decodes
  always_comb begin
    word_c      = {shift_q, data_in};
    last_bit_c  = (bit_cnt_q == BW'(WIDTH - 1));
    last_slot_c = (slot_cnt_q == SW'(NUM_CH - 1));
    resync_c    = sync_in && ((bit_cnt_q != '0) || (slot_cnt_q != '0));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      slot_cnt_q   <= '0;
      shift_q      <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;

      // Everything freezes while valid_in is low
      if (valid_in) begin
        case (state_q)
          HUNT: begin
            if (sync_in) begin
              shift_q    <= SHW'(data_in);
              bit_cnt_q  <= BW'(1);
              slot_cnt_q <= '0;
              state_q    <= RECEIVE;
              locked_q   <= 1'b1;
            end
          end

          RECEIVE: begin
            if (resync_c) begin
              // Abandon the partial frame; this bit opens a fresh slot 0
              sync_err_q <= 1'b1;
              shift_q    <= SHW'(data_in);
              bit_cnt_q  <= BW'(1);
              slot_cnt_q <= '0;
            end else begin
              shift_q <= word_c[SHW-1:0];
              if (last_bit_c) begin
                bit_cnt_q <= '0;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                  if (slot_cnt_q == SW'(c)) begin
                    ch_data_q[c*WIDTH +: WIDTH] <= word_c;
                    ch_valid_q[c]               <= 1'b1;
                  end
                end
                if (last_slot_c) begin
                  frame_done_q <= 1'b1;
                  slot_cnt_q   <= '0;
                  state_q      <= EXPECT;
                end else begin
                  slot_cnt_q <= slot_cnt_q + SW'(1);
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end
          end

          EXPECT: begin
            if (sync_in) begin
              shift_q    <= SHW'(data_in);
              bit_cnt_q  <= BW'(1);
              slot_cnt_q <= '0;
              state_q    <= RECEIVE;
            end else begin
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
              locked_q   <= 1'b0;
            end
          end

          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_data_out    = ch_data_q;
  assign ch_valid_out   = ch_valid_q;
  assign frame_done_out = frame_done_q;
  assign sync_err_out   = sync_err_q;
  assign locked_out     = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus pushes expected output events,
// a monitor thread pops and compares whenever the DUT strobes.
module tb_tdm_demux;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WIDTH  = 8;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    data_in;
  logic                    valid_in;
  logic                    sync_in;
  logic [NUM_CH*WIDTH-1:0] ch_data_out;
  logic [NUM_CH-1:0]       ch_valid_out;
  logic                    frame_done_out;
  logic                    sync_err_out;
  logic                    locked_out;

  always #5 clk_in = ~clk_in;

  tdm_demux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .sync_in        (sync_in),
    .ch_data_out    (ch_data_out),
    .ch_valid_out   (ch_valid_out),
    .frame_done_out (frame_done_out),
    .sync_err_out   (sync_err_out),
    .locked_out     (locked_out)
  );

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        fd;
    logic        err;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] exp_data;
  int          errors;
  int          checks;
  int          n_ev;

  task automatic drive(input logic v, input logic d, input logic s);
    valid_in = v;
    data_in  = d;
    sync_in  = s;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_slot(input int c, input logic [7:0] b);
    ev_t ev;
    exp_data[c*8 +: 8] = b;
    ev.vld  = 4'(1 << c);
    ev.data = exp_data;
    ev.fd   = (c == 3);
    ev.err  = 1'b0;
    exp_q.push_back(ev);
  endtask

  task automatic push_err();
    ev_t ev;
    ev.vld  = 4'b0000;
    ev.data = exp_data;
    ev.fd   = 1'b0;
    ev.err  = 1'b1;
    exp_q.push_back(ev);
  endtask

  // Send the top nbits of b MSB first; idle cycles carry junk that must be ignored
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic sync_first, input int gap);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, b[7-i], sync_first && (i == 0));
      repeat (gap) drive(1'b0, 1'b1, 1'b1);
    end
  endtask

  // bytes_le holds slot 0 in bits [7:0]
  task automatic send_frame(input logic [31:0] bytes_le, input int gap);
    for (int c = 0; c < 4; c++) begin
      push_slot(c, bytes_le[c*8 +: 8]);
      send_bits(bytes_le[c*8 +: 8], 8, (c == 0), gap);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    n_ev     = 0;
    exp_data = '0;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;
    sync_in  = 1'b0;

    fork
      begin : monitor
        ev_t got;
        ev_t want;
        forever begin
          @(negedge clk_in);
          if ((ch_valid_out != '0) || frame_done_out || sync_err_out) begin
            checks++;
            n_ev++;
            got = {ch_valid_out, ch_data_out, frame_done_out, sync_err_out};
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL event%0d unexpected: vld=%b data=%h fd=%b err=%b",
                       n_ev, got.vld, got.data, got.fd, got.err);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                errors++;
                $display("FAIL event%0d: got vld=%b data=%h fd=%b err=%b want vld=%b data=%h fd=%b err=%b",
                         n_ev, got.vld, got.data, got.fd, got.err,
                         want.vld, want.data, want.fd, want.err);
              end
            end
          end
        end
      end

      begin : stimulus
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("rst_data", ch_data_out, 32'h0);
        check("rst_valid", 32'(ch_valid_out), 32'h0);
        check("rst_fd", 32'(frame_done_out), 32'h0);
        check("rst_err", 32'(sync_err_out), 32'h0);
        check("rst_locked", 32'(locked_out), 32'h0);
        rst_in = 1'b0;

        // HUNT discards bits without sync
        send_bits(8'hFF, 8, 1'b0, 0);
        check("hunt_locked", 32'(locked_out), 32'h0);

        // Single frame
        send_frame(32'h01FF3CA5, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("frame1_data", ch_data_out, 32'h01FF3CA5);
        check("frame1_locked", 32'(locked_out), 32'h1);

        // Back-to-back frame
        send_frame(32'h44332211, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("frame2_data", ch_data_out, 32'h44332211);

        // Gapped valid
        send_frame(32'h01FF3CA5, 3);
        drive(1'b0, 1'b0, 1'b0);
        check("gapped_data", ch_data_out, 32'h01FF3CA5);

        // Missing sync at the frame boundary
        push_err();
        drive(1'b1, 1'b0, 1'b0);
        check("nosync_locked", 32'(locked_out), 32'h0);
        check("nosync_data", ch_data_out, 32'h01FF3CA5);
        drive(1'b1, 1'b1, 1'b0);
        send_frame(32'h44332211, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("relock_data", ch_data_out, 32'h44332211);
        check("relock_locked", 32'(locked_out), 32'h1);

        // Mid-frame resync at bit 3 of slot 1
        push_slot(0, 8'hC5);
        send_bits(8'hC5, 8, 1'b1, 0);
        send_bits(8'hB7, 3, 1'b0, 0);
        push_err();
        send_frame(32'hF00FC35A, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("resync_data", ch_data_out, 32'hF00FC35A);
        check("resync_locked", 32'(locked_out), 32'h1);

        // Reset at bit 5 of slot 2
        push_slot(0, 8'h12);
        send_bits(8'h12, 8, 1'b1, 0);
        push_slot(1, 8'h34);
        send_bits(8'h34, 8, 1'b0, 0);
        send_bits(8'h56, 5, 1'b0, 0);
        rst_in = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        rst_in   = 1'b0;
        exp_data = '0;
        check("midrst_data", ch_data_out, 32'h0);
        check("midrst_valid", 32'(ch_valid_out), 32'h0);
        check("midrst_locked", 32'(locked_out), 32'h0);
        send_bits(8'hFF, 8, 1'b0, 0);
        send_bits(8'hA5, 8, 1'b0, 0);
        check("postrst_data", ch_data_out, 32'h0);
        check("postrst_locked", 32'(locked_out), 32'h0);
        send_frame(32'h04030201, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("postrst_frame", ch_data_out, 32'h04030201);
        check("postrst_relock", 32'(locked_out), 32'h1);

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
      end

      begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: time limit reached, %0d events still pending", exp_q.size());
      end
    join_any

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
